// File: rtl/pipe_hazard_ctrl_if.sv
// Bundles the pipeline-side hazard inputs and the stall/flush controls of pipe_hazard_ctrl.
// The master drives the ID/EXE observations; the slave (the controller) returns stall/flush.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_RegisterRs;
    logic [4:0]  id_RegisterRt;
    logic        id_UsesRt;
    logic        id_MulDiv;
    logic        exe_MemRead;
    logic [4:0]  exe_RegisterRt;
    logic        branch_taken;
    logic        stall_pc;
    logic        stall_ifid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        md_busy;
    logic        md_done;
    logic [15:0] stall_count;

    modport master (
        output id_RegisterRs, id_RegisterRt, id_UsesRt, id_MulDiv,
        output exe_MemRead, exe_RegisterRt, branch_taken,
        input  stall_pc, stall_ifid, flush_ifid, flush_idex, md_busy, md_done, stall_count
    );

    modport slave (
        input  id_RegisterRs, id_RegisterRt, id_UsesRt, id_MulDiv,
        input  exe_MemRead, exe_RegisterRt, branch_taken,
        output stall_pc, stall_ifid, flush_ifid, flush_idex, md_busy, md_done, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use stall and multi-cycle mul/div stall,
// with a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic ST_RUN     = 1'b0;
    localparam logic ST_MD_BUSY = 1'b1;

    logic        r_state;
    logic [15:0] r_md_cnt;
    logic [15:0] r_stall_count;

    logic        w_state_d;
    logic [15:0] w_md_cnt_d;
    logic        w_load_use;
    logic        w_stall_pc;
    logic        w_stall_ifid;
    logic        w_flush_ifid;
    logic        w_flush_idex;
    logic        w_md_done;

    assign w_load_use = bus.exe_MemRead && (bus.exe_RegisterRt != 5'd0) &&
                        ((bus.exe_RegisterRt == bus.id_RegisterRs) ||
                         (bus.id_UsesRt && (bus.exe_RegisterRt == bus.id_RegisterRt)));

    always_comb begin
        w_state_d    = r_state;
        w_md_cnt_d   = r_md_cnt;
        w_stall_pc   = 1'b0;
        w_stall_ifid = 1'b0;
        w_flush_ifid = 1'b0;
        w_flush_idex = 1'b0;
        w_md_done    = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (bus.branch_taken) begin
                        w_flush_ifid = 1'b1;
                        w_flush_idex = 1'b1;
                    end else if (w_load_use) begin
                        w_stall_pc   = 1'b1;
                        w_stall_ifid = 1'b1;
                        w_flush_idex = 1'b1;
                    end else if (bus.id_MulDiv) begin
                        w_stall_pc   = 1'b1;
                        w_stall_ifid = 1'b1;
                        w_flush_idex = 1'b1;
                        w_state_d    = ST_MD_BUSY;
                        w_md_cnt_d   = 16'(MD_LAT - 1);
                    end
                end
                default: begin
                    // EXE only holds bubbles here, so branch/load-use/mul-div inputs are ignored
                    if (r_md_cnt != 16'd0) begin
                        w_stall_pc   = 1'b1;
                        w_stall_ifid = 1'b1;
                        w_flush_idex = 1'b1;
                        w_md_cnt_d   = r_md_cnt - 16'd1;
                    end else begin
                        w_md_done = 1'b1;
                        w_state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_md_cnt      <= 16'd0;
            r_stall_count <= 16'd0;
        end else begin
            r_state  <= w_state_d;
            r_md_cnt <= w_md_cnt_d;
            if (w_stall_pc && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign bus.stall_pc    = w_stall_pc;
    assign bus.stall_ifid  = w_stall_ifid;
    assign bus.flush_ifid  = w_flush_ifid;
    assign bus.flush_idex  = w_flush_idex;
    assign bus.md_done     = w_md_done;
    assign bus.md_busy     = r_state;
    assign bus.stall_count = r_stall_count;
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MD_LAT, default 32; total stall cycles for a multi-cycle mul/div op; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 id_RegisterRs  input  5  rs field of the instruction in ID.
REQ-005 id_RegisterRt  input  5  rt field of the instruction in ID.
REQ-006 id_UsesRt  input  1  the ID instruction reads rt as a source.
REQ-007 id_MulDiv  input  1  the ID instruction is a multi-cycle mul/div.
REQ-008 exe_MemRead  input  1  the EXE instruction is a load.
REQ-009 exe_RegisterRt  input  5  destination register of the EXE load.
REQ-010 branch_taken  input  1  branch/jump resolved taken in EXE this cycle.
REQ-011 stall_pc  output  1  hold PC.
REQ-012 stall_ifid  output  1  hold the IF/ID register.
REQ-013 flush_ifid  output  1  zero the IF/ID register at the next edge.
REQ-014 flush_idex  output  1  load a bubble (all zeros) into the ID/EX register at the next edge.
REQ-015 md_busy  output  1  FSM is in MD_BUSY.
REQ-016 md_done  output  1  one-cycle pulse on mul/div stall release.
REQ-017 stall_count  output  16  saturating count of cycles with stall_pc=1.

Function
REQ-018 The FSM SHALL have two states: RUN (encoding 0) and MD_BUSY (encoding 1), plus a 16-bit down-counter md_cnt.
REQ-019 Load-use hazard SHALL be: exe_MemRead=1, exe_RegisterRt!=0, and (exe_RegisterRt==id_RegisterRs or (id_UsesRt=1 and exe_RegisterRt==id_RegisterRt)).
REQ-020 Priority in RUN SHALL be: branch_taken > load-use > id_MulDiv.
REQ-021 RUN with branch_taken=1: flush_ifid=1, flush_idex=1, stall_pc=0, stall_ifid=0; stay in RUN; any pending hazard or mul/div in ID is discarded.
REQ-022 RUN with load-use (no branch): stall_pc=1, stall_ifid=1, flush_idex=1, flush_ifid=0; stay in RUN; one stall cycle per hazard.
REQ-023 RUN with id_MulDiv=1 (no branch, no load-use): stall_pc=1, stall_ifid=1, flush_idex=1; next state MD_BUSY; md_cnt <= MD_LAT-1.
REQ-024 MD_BUSY with md_cnt!=0: stall_pc=1, stall_ifid=1, flush_idex=1, flush_ifid=0; md_cnt decrements by 1.
REQ-025 MD_BUSY with md_cnt==0: all stall/flush outputs 0, md_done=1; the mul/div advances to EXE at this edge; next state RUN.
REQ-026 A mul/div op SHALL therefore stall exactly MD_LAT cycles, with release on cycle MD_LAT+1 counted from detection.
REQ-027 branch_taken, load-use and id_MulDiv SHALL be ignored in MD_BUSY, because EXE holds bubbles.
REQ-028 Stall/flush outputs and md_done SHALL be combinational from state and inputs; md_busy SHALL be registered state.
REQ-029 RUN with no event: all stall/flush outputs 0 and md_done=0.
REQ-030 stall_count SHALL increment each cycle stall_pc=1 and SHALL hold at 16'hFFFF once reached.

Reset
REQ-031 rst=1 at a clock edge SHALL set the state to RUN, md_cnt=0, and stall_count=0.
REQ-032 While rst=1, stall_pc, stall_ifid, flush_ifid, flush_idex and md_done SHALL all be 0.
REQ-033 Reset asserted during MD_BUSY SHALL abort the op with no md_done pulse; the next cycle after rst falls is RUN.

Verification
REQ-034 Load-use: exe_MemRead=1, exe_RegisterRt=5, id_RegisterRs=5 -> stall_pc=stall_ifid=flush_idex=1 for exactly 1 cycle; stall_count=1.
REQ-035 Load-use suppressed: exe_RegisterRt=0 = id_RegisterRs; and separately rt match with id_UsesRt=0 -> no stall in either case.
REQ-036 MD_LAT=4, id_MulDiv=1 at cycle 0 -> stall on cycles 0-3, md_busy on cycles 1-4, md_done=1 and stalls 0 on cycle 4, RUN on cycle 5; stall_count=4.
REQ-037 branch_taken=1 together with load-use and id_MulDiv=1 -> flush_ifid=flush_idex=1, stall_pc=0, no entry to MD_BUSY.
REQ-038 rst=1 on cycle 2 of a MD_LAT=8 op -> RUN, stall_count=0, no md_done pulse; 70000 continuous stall cycles -> stall_count saturates at 65535.
